// File: rtl/uart_cmd_input_handler_if.sv
// Byte-stream input and decoded command output bundle for uart_cmd_input_handler.
// The slave side is the parser; the master side feeds bytes and consumes frames.
interface uart_cmd_input_handler_if;
    logic        byte_available;
    logic [7:0]  rx_byte;
    logic [31:0] command;
    logic [31:0] address;
    logic [31:0] data;
    logic        ready;

    modport master (
        output byte_available,
        output rx_byte,
        input  command,
        input  address,
        input  data,
        input  ready
    );

    modport slave (
        input  byte_available,
        input  rx_byte,
        output command,
        output address,
        output data,
        output ready
    );
endinterface

// File: rtl/uart_cmd_input_handler.sv
// ASCII-hex frame parser: a start character followed by command, address and data hex digits
// is decoded into three 32-bit words, announced by a one-cycle ready pulse.
module uart_cmd_input_handler #(
    parameter logic [7:0]  START_CHAR = 8'h4C,
    parameter int unsigned NUM_DIGITS = 24
) (
    input logic                      clk,
    input logic                      rst,
    uart_cmd_input_handler_if.slave  bus
);

    localparam int unsigned SrW  = 4 * NUM_DIGITS;
    localparam int unsigned CntW = $clog2(NUM_DIGITS + 1);
    localparam logic [CntW-1:0] LastCnt = CntW'(NUM_DIGITS - 1);

    // The start character is accepted in either letter case.
    localparam logic StartIsAlpha = ((START_CHAR | 8'h20) >= 8'h61) &&
                                    ((START_CHAR | 8'h20) <= 8'h7A);
    localparam logic [7:0] StartAlt = StartIsAlpha ? (START_CHAR ^ 8'h20) : START_CHAR;

    typedef enum logic [0:0] {StIdle, StRead} state_e;

    state_e           state_q;
    logic [CntW-1:0]  count_q;
    logic [SrW-1:0]   sr_q;
    logic [31:0]      command_q;
    logic [31:0]      address_q;
    logic [31:0]      data_q;
    logic             ready_q;

    logic             is_ws;
    logic             is_start;
    logic             is_hex;
    logic [3:0]       nib;
    logic [SrW-1:0]   sr_next;

    always_comb begin
        is_ws    = (bus.rx_byte == 8'h20) || (bus.rx_byte == 8'h09) ||
                   (bus.rx_byte == 8'h0D) || (bus.rx_byte == 8'h0A);
        is_start = (bus.rx_byte == START_CHAR) || (bus.rx_byte == StartAlt);
        is_hex   = 1'b0;
        nib      = 4'h0;
        if (bus.rx_byte >= 8'h30 && bus.rx_byte <= 8'h39) begin
            is_hex = 1'b1;
            nib    = bus.rx_byte[3:0];
        end else if ((bus.rx_byte >= 8'h41 && bus.rx_byte <= 8'h46) ||
                     (bus.rx_byte >= 8'h61 && bus.rx_byte <= 8'h66)) begin
            is_hex = 1'b1;
            nib    = bus.rx_byte[3:0] + 4'd9;
        end
        sr_next = {sr_q[SrW-5:0], nib};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            count_q   <= '0;
            sr_q      <= '0;
            command_q <= '0;
            address_q <= '0;
            data_q    <= '0;
            ready_q   <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            if (bus.byte_available && !is_ws) begin
                unique case (state_q)
                    StIdle: begin
                        if (is_start) begin
                            state_q <= StRead;
                            count_q <= '0;
                            sr_q    <= '0;
                        end
                    end
                    StRead: begin
                        if (is_hex) begin
                            sr_q <= sr_next;
                            if (count_q == LastCnt) begin
                                // Publish the completed frame including this final nibble.
                                command_q <= sr_next[SrW-1 -: 32];
                                address_q <= sr_next[SrW-33 -: 32];
                                data_q    <= sr_next[SrW-65 -: 32];
                                ready_q   <= 1'b1;
                                count_q   <= '0;
                                state_q   <= StIdle;
                            end else begin
                                count_q <= count_q + 1'b1;
                            end
                        end else if (is_start) begin
                            count_q <= '0;
                            sr_q    <= '0;
                        end else begin
                            state_q <= StIdle;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign bus.command = command_q;
    assign bus.address = address_q;
    assign bus.data    = data_q;
    assign bus.ready   = ready_q;

endmodule

// File: tb/tb_uart_cmd_input_handler.sv
// Scoreboard bench for uart_cmd_input_handler: stimulus queues expected frames, a monitor
// pops and compares on every ready pulse.
module tb_uart_cmd_input_handler;

    logic clk;
    logic rst;

    uart_cmd_input_handler_if bus ();

    uart_cmd_input_handler dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] command;
        logic [31:0] address;
        logic [31:0] data;
    } frame_t;

    frame_t exp_q[$];
    int     checks     = 0;
    int     errors     = 0;
    int     pulses     = 0;
    int     exp_pulses = 0;
    logic   ready_prev = 1'b0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic expect_frame(input logic [31:0] c, input logic [31:0] a, input logic [31:0] d);
        frame_t f;
        f.command = c;
        f.address = a;
        f.data    = d;
        exp_q.push_back(f);
        exp_pulses++;
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are sampled on falling edges.
    task automatic send_str(input string s, input int gap);
        for (int i = 0; i < s.len(); i++) begin
            bus.rx_byte        = s[i];
            bus.byte_available = 1'b1;
            @(posedge clk);
            #1;
            bus.byte_available = 1'b0;
            for (int g = 1; g < gap; g++) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: every ready pulse must match the oldest queued frame and last one cycle.
    always @(negedge clk) begin
        if (!rst && bus.ready === 1'b1) begin
            frame_t f;
            pulses++;
            check32("ready_single_cycle", {31'd0, ready_prev}, 32'd0);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ready: got ready=1 expected no pulse (cmd 0x%08h)",
                         bus.command);
            end else begin
                f = exp_q.pop_front();
                check32("command", bus.command, f.command);
                check32("address", bus.address, f.address);
                check32("data",    bus.data,    f.data);
            end
        end
        ready_prev = bus.ready;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        bus.byte_available = 1'b0;
        bus.rx_byte        = 8'h00;
        rst                = 1'b1;

        // 1: bytes during reset are ignored
        @(posedge clk);
        #1;
        send_str("L0", 1);
        rst = 1'b0;
        @(negedge clk);
        check32("reset_command", bus.command, 32'h0);
        check32("reset_address", bus.address, 32'h0);
        check32("reset_data",    bus.data,    32'h0);
        check32("reset_ready",   {31'd0, bus.ready}, 32'h0);
        idle(2);

        // 2: spaced single-cycle pulses
        expect_frame(32'h00000001, 32'h00000000, 32'h12345678);
        send_str("L000000010000000012345678", 3);
        idle(3);

        // 3: lowercase start, whitespace inside and after the frame
        expect_frame(32'h00000001, 32'h01000000, 32'hABCDEF01);
        send_str("l00000001 01000000\tabcdef01\r\n", 1);
        idle(3);

        // 4: aborted frame leaves outputs untouched, then a valid frame
        send_str("L0000G", 1);
        idle(3);
        check32("abort_hold_command", bus.command, 32'h00000001);
        check32("abort_hold_data",    bus.data,    32'hABCDEF01);
        expect_frame(32'h2, 32'h1, 32'h3);
        send_str("L000000020000000100000003", 2);
        idle(3);

        // 5: restart mid-frame; trailing hex digits after completion are idle bytes
        expect_frame(32'hFFFFFFFF, 32'h00000000, 32'hAAAAAAAA);
        send_str("L12LFFFFFFFF00000000AAAAAAAA9999", 1);
        idle(3);
        check32("trailing_hold_data", bus.data, 32'hAAAAAAAA);

        // back-to-back frames: next start byte lands while ready is high
        expect_frame(32'h11111111, 32'h22222222, 32'h33333333);
        expect_frame(32'hDEADBEEF, 32'hCAFEF00D, 32'h0BADC0DE);
        send_str("L111111112222222233333333LdeadbeefCAFEf00d0badc0de", 1);
        idle(3);

        // 6: reset after 10 digits discards the partial frame
        send_str("L0123456789", 1);
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        @(negedge clk);
        check32("midreset_command", bus.command, 32'h0);
        check32("midreset_address", bus.address, 32'h0);
        check32("midreset_data",    bus.data,    32'h0);
        expect_frame(32'h0000000A, 32'h0000000B, 32'h0000000C);
        send_str("abcdef", 1);
        send_str("L0000000A0000000B", 1);
        @(negedge clk);
        check32("no_partial_command", bus.command, 32'h0);
        send_str("0000000C", 1);
        idle(5);

        check32("queue_drained", exp_q.size(), 32'd0);
        check32("pulse_count", pulses, exp_pulses);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
